mode_ctrl: RTL and testbench
============================

Name: mode_ctrl

Overview:
- Front-panel mode controller that sequences the display digit mux between clock, alarm and stopwatch views.
- Converts debounced button levels into the 2-bit mode select that drives the mux.
- Drives edit enables, field select and increment pulses to the clock and alarm time registers.
- Returns to clock view after an inactivity timeout, counted on the 1 Hz tick.

Parameters:
TIMEOUT_S, 10, number of tick_1hz pulses with no button edge before auto-return to CLOCK; 0 disables the timeout
CNT_W, 6, width of the timeout counter; TIMEOUT_S must not exceed 2^CNT_W-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
tick_1hz  input  1  one-cycle pulse once per second
btn_mode  input  1  debounced level, mode-cycle button
btn_set  input  1  debounced level, enter/advance edit button
btn_up  input  1  debounced level, increment button
mode  output  2  digit mux select: 00 clock, 10 alarm, 11 stopwatch
edit_clk  output  1  clock time register in edit
edit_alm  output  1  alarm time register in edit
edit_sel  output  1  1 = left pair (hours) selected, 0 = right pair (minutes)
inc_pulse  output  1  one-cycle increment strobe to the selected field
blank_left  output  1  blank the left digit pair (blink)
blank_right  output  1  blank the right digit pair (blink)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - State CLOCK; mode=00; edit_clk=edit_alm=edit_sel=inc_pulse=0; blank_left=blank_right=0.
  - Timeout counter=0.
  - Button history registers reset to 1, so a button held through reset is not seen as an edge.
- Edge detect: edge = btn & ~btn_q. Latency: outputs change at the same clk edge that first samples a button high.
- Priority on a simultaneous edge: btn_mode > btn_set > btn_up. Only the highest-priority edge acts that cycle; the lower ones are discarded.
- States and transitions (M = mode edge, S = set edge, T = timeout):
  - CLOCK: M -> ALARM; S -> CLK_EDIT_H.
  - ALARM: M -> STOPWATCH; S -> ALM_EDIT_H; T -> CLOCK.
  - STOPWATCH: M -> CLOCK. S and up edges are ignored; the stopwatch has its own controls. No timeout.
  - CLK_EDIT_H: S -> CLK_EDIT_M; M -> CLOCK; T -> CLOCK.
  - CLK_EDIT_M: S -> CLOCK; M -> CLOCK; T -> CLOCK.
  - ALM_EDIT_H: S -> ALM_EDIT_M; M -> ALARM; T -> CLOCK.
  - ALM_EDIT_M: S -> ALARM; M -> ALARM; T -> CLOCK.
- Output decode:
  - mode=00 in CLOCK and CLK_EDIT_*; 10 in ALARM and ALM_EDIT_*; 11 in STOPWATCH. Codes 01 never driven.
  - edit_clk=1 only in CLK_EDIT_*; edit_alm=1 only in ALM_EDIT_*.
  - edit_sel=1 in *_EDIT_H, 0 otherwise.
- inc_pulse:
  - High for exactly one cycle per up edge, only in edit states; the edge must not be pre-empted by M or S that cycle.
  - A held btn_up produces exactly one pulse.
  - Digit wrap is the target register's job, not this block's.
- Timeout counter:
  - Cleared on any button edge, on any state change, and while in CLOCK or STOPWATCH.
  - Otherwise increments on tick_1hz and saturates at 2^CNT_W-1.
  - T asserts when the counter = TIMEOUT_S-1 and tick_1hz=1.
  - If a button edge coincides with T, the button wins and the counter clears.
- Edit state exit: in-progress edits are already committed via inc_pulse; exiting an edit state performs no rollback.
- rst asserted mid-operation overrides everything that cycle, including a pending inc_pulse; the block returns to reset values.

Optional Feature:
Macro BLINK_EN.
- Defined:
  - A blink phase register toggles on each tick_1hz while in an edit state and clears on entry to any edit state.
  - While the phase is 1: blank_left=1 in *_EDIT_H, blank_right=1 in *_EDIT_M.
  - Any up edge forces the phase to 0, so the field is visible while incrementing.
- Undefined: blank_left and blank_right are tied to 0 and no phase register exists.

Test Plan:
- Reset held with btn_mode=1, then released with btn_mode still high -> mode stays 00; no transition until btn_mode falls and rises again.
- Three btn_mode rises from CLOCK -> mode sequence 10, 11, 00; each change lands on the edge that samples the rise.
- CLOCK, S, up x3, S, up x2, S -> edit_clk=1 throughout until the final S; edit_sel 1 for the first three pulses, 0 for the next two; five single-cycle inc_pulses; final state CLOCK with edit_clk=0.
- ALARM with TIMEOUT_S=10 and no buttons -> mode returns 00 on the 10th tick_1hz. The same run with a btn_up rise at tick 9 (no effect in ALARM) restarts the count, and the return occurs 10 ticks after that edge.
- In ALM_EDIT_M, btn_mode and btn_set rise in the same cycle -> state ALARM via the M rule, no extra advance; btn_up rising in that same cycle gives no inc_pulse.
- With BLINK_EN, in CLK_EDIT_H over 4 ticks -> blank_left toggles 1,0,1,0 and blank_right stays 0; an up edge mid-phase forces blank_left=0 the next cycle.

Source files
------------

// File: rtl/mode_ctrl.sv
// Front-panel mode controller: cycles the display between clock, alarm and stopwatch
// views, drives time-register edit strobes, and falls back to clock view on inactivity.
// Optional blinking of the field being edited is enabled by defining BLINK_EN.
module mode_ctrl #(
    parameter int TIMEOUT_S = 10,
    parameter int CNT_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_up,
    output logic [1:0] mode,
    output logic       edit_clk,
    output logic       edit_alm,
    output logic       edit_sel,
    output logic       inc_pulse,
    output logic       blank_left,
    output logic       blank_right
);

    typedef enum logic [2:0] {
        ST_CLOCK,
        ST_ALARM,
        ST_STOPWATCH,
        ST_CLK_EDIT_H,
        ST_CLK_EDIT_M,
        ST_ALM_EDIT_H,
        ST_ALM_EDIT_M
    } state_t;

    localparam logic [CNT_W-1:0] T_LAST  = CNT_W'((TIMEOUT_S == 0) ? 0 : TIMEOUT_S - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_n;
    logic [2:0]       btn_q;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             m_edge, s_edge, u_edge, any_edge;
    logic             timed, t_hit, inc_n;
    logic [1:0]       mode_n;
    logic             edit_clk_n, edit_alm_n, edit_sel_n;

    function automatic logic is_edit(input state_t s);
        return (s == ST_CLK_EDIT_H) || (s == ST_CLK_EDIT_M) ||
               (s == ST_ALM_EDIT_H) || (s == ST_ALM_EDIT_M);
    endfunction

    assign m_edge   = btn_mode & ~btn_q[2];
    assign s_edge   = btn_set  & ~btn_q[1];
    assign u_edge   = btn_up   & ~btn_q[0];
    assign any_edge = m_edge | s_edge | u_edge;
    assign timed    = (state != ST_CLOCK) && (state != ST_STOPWATCH);
    assign t_hit    = (TIMEOUT_S != 0) && tick_1hz && timed && (cnt == T_LAST);

    // Outputs are decoded from the next state so they register on the same
    // edge that samples the button.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_n = state;
        if (m_edge) begin
            case (state)
                ST_CLOCK:      state_n = ST_ALARM;
                ST_ALARM:      state_n = ST_STOPWATCH;
                ST_STOPWATCH:  state_n = ST_CLOCK;
                ST_CLK_EDIT_H,
                ST_CLK_EDIT_M: state_n = ST_CLOCK;
                ST_ALM_EDIT_H,
                ST_ALM_EDIT_M: state_n = ST_ALARM;
                default:       state_n = ST_CLOCK;
            endcase
        end else if (s_edge) begin
            case (state)
                ST_CLOCK:      state_n = ST_CLK_EDIT_H;
                ST_ALARM:      state_n = ST_ALM_EDIT_H;
                ST_STOPWATCH:  state_n = ST_STOPWATCH;
                ST_CLK_EDIT_H: state_n = ST_CLK_EDIT_M;
                ST_CLK_EDIT_M: state_n = ST_CLOCK;
                ST_ALM_EDIT_H: state_n = ST_ALM_EDIT_M;
                ST_ALM_EDIT_M: state_n = ST_ALARM;
                default:       state_n = ST_CLOCK;
            endcase
        end else if (!u_edge && t_hit) begin
            state_n = ST_CLOCK;
        end

        cnt_n = cnt;
        if (any_edge || (state_n != state) || !timed)
            cnt_n = '0;
        else if (tick_1hz && (cnt != CNT_MAX))
            cnt_n = cnt + 1'b1;

        inc_n = u_edge & ~m_edge & ~s_edge & is_edit(state);

        mode_n = 2'b00;
        if ((state_n == ST_ALARM) || (state_n == ST_ALM_EDIT_H) || (state_n == ST_ALM_EDIT_M))
            mode_n = 2'b10;
        else if (state_n == ST_STOPWATCH)
            mode_n = 2'b11;
        edit_clk_n = (state_n == ST_CLK_EDIT_H) || (state_n == ST_CLK_EDIT_M);
        edit_alm_n = (state_n == ST_ALM_EDIT_H) || (state_n == ST_ALM_EDIT_M);
        edit_sel_n = (state_n == ST_CLK_EDIT_H) || (state_n == ST_ALM_EDIT_H);
    end

`ifdef BLINK_EN
    logic phase, phase_n;
    logic blank_left_n, blank_right_n;

    // The phase restarts visible on entry to an edit state and while incrementing.
    always_comb begin
        phase_n = phase;
        if (is_edit(state_n) && (state_n != state))
            phase_n = 1'b0;
        else if (u_edge)
            phase_n = 1'b0;
        else if (tick_1hz && is_edit(state))
            phase_n = ~phase;
        blank_left_n  = phase_n && edit_sel_n;
        blank_right_n = phase_n && is_edit(state_n) && !edit_sel_n;
    end
`else
    assign blank_left  = 1'b0;
    assign blank_right = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLOCK;
            btn_q     <= '1;
            cnt       <= '0;
            mode      <= 2'b00;
            edit_clk  <= 1'b0;
            edit_alm  <= 1'b0;
            edit_sel  <= 1'b0;
            inc_pulse <= 1'b0;
`ifdef BLINK_EN
            phase       <= 1'b0;
            blank_left  <= 1'b0;
            blank_right <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            btn_q     <= {btn_mode, btn_set, btn_up};
            cnt       <= cnt_n;
            mode      <= mode_n;
            edit_clk  <= edit_clk_n;
            edit_alm  <= edit_alm_n;
            edit_sel  <= edit_sel_n;
            inc_pulse <= inc_n;
`ifdef BLINK_EN
            phase       <= phase_n;
            blank_left  <= blank_left_n;
            blank_right <= blank_right_n;
`endif
        end
    end

endmodule

// File: tb/tb_mode_ctrl.sv
// Self-checking bench for mode_ctrl: directed scenarios followed by randomized button
// and tick traffic, all checked against a view/field reference model.
module tb_mode_ctrl;

    localparam int TIMEOUT_S = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0, btn_set = 1'b0, btn_up = 1'b0;
    logic [1:0] mode;
    logic       edit_clk, edit_alm, edit_sel, inc_pulse, blank_left, blank_right;

    int checks = 0;
    int errors = 0;
    int inc_seen = 0;

    // Reference model: view 0 clock / 1 alarm / 2 stopwatch; field 0 none / 2 hours / 1 minutes.
    int view, field, idle;
    bit pm, ps, pu, phase, e_inc;

    mode_ctrl #(.TIMEOUT_S(TIMEOUT_S), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_set(btn_set), .btn_up(btn_up),
        .mode(mode), .edit_clk(edit_clk), .edit_alm(edit_alm), .edit_sel(edit_sel),
        .inc_pulse(inc_pulse), .blank_left(blank_left), .blank_right(blank_right)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        view = 0; field = 0; idle = 0;
        pm = 1; ps = 1; pu = 1; phase = 0; e_inc = 0;
    endtask

    task automatic model_step(input bit m, input bit s, input bit u, input bit t);
        bit me, se, ue, timed, changed;
        int ov, of;
        me = m && !pm; se = s && !ps; ue = u && !pu;
        pm = m; ps = s; pu = u;
        ov = view; of = field; e_inc = 0;
        timed = (view == 1) || (view == 0 && field != 0);
        if (me) begin
            if (field != 0) field = 0;
            else view = (view + 1) % 3;
        end else if (se) begin
            if (view != 2) field = (field == 0) ? 2 : (field == 2) ? 1 : 0;
        end else if (ue) begin
            e_inc = (field != 0);
        end else if (t && timed && TIMEOUT_S > 0 && idle + 1 == TIMEOUT_S) begin
            view = 0; field = 0;
        end
        changed = (view != ov) || (field != of);
        if (me || se || ue || changed || !timed) idle = 0;
        else if (t && idle < 63) idle++;
        if (field != 0 && changed) phase = 0;
        else if (ue) phase = 0;
        else if (t && of != 0) phase = !phase;
    endtask

    task automatic check_all();
        logic [1:0] em;
        bit bl, br;
        em = (view == 0) ? 2'b00 : (view == 1) ? 2'b10 : 2'b11;
`ifdef BLINK_EN
        bl = phase && field == 2;
        br = phase && field == 1;
`else
        bl = 0; br = 0;
`endif
        chk("mode", mode, em);
        chk("edit_clk", {1'b0, edit_clk}, {1'b0, field != 0 && view == 0});
        chk("edit_alm", {1'b0, edit_alm}, {1'b0, field != 0 && view == 1});
        chk("edit_sel", {1'b0, edit_sel}, {1'b0, field == 2});
        chk("inc_pulse", {1'b0, inc_pulse}, {1'b0, e_inc});
        chk("blank_left", {1'b0, blank_left}, {1'b0, bl});
        chk("blank_right", {1'b0, blank_right}, {1'b0, br});
    endtask

    task automatic cyc();
        @(posedge clk); #1;
        if (rst) model_reset();
        else model_step(btn_mode, btn_set, btn_up, tick_1hz);
        check_all();
        if (inc_pulse) inc_seen++;
    endtask

    task automatic press_m(); btn_mode = 1; cyc(); btn_mode = 0; cyc(); endtask
    task automatic press_s(); btn_set = 1; cyc(); btn_set = 0; cyc(); endtask
    task automatic press_u(); btn_up = 1; cyc(); btn_up = 0; cyc(); endtask
    task automatic tick(); tick_1hz = 1; cyc(); tick_1hz = 0; cyc(); cyc(); endtask

    initial begin
        // Reset held with btn_mode high, released while still high.
        rst = 1; btn_mode = 1;
        repeat (3) cyc();
        chk("reset_mode", mode, 2'b00);
        rst = 0;
        repeat (3) cyc();
        chk("held_through_reset", mode, 2'b00);
        btn_mode = 0; cyc();
        btn_mode = 1; cyc();
        chk("m_rise_1", mode, 2'b10);
        btn_mode = 0; cyc(); btn_mode = 1; cyc();
        chk("m_rise_2", mode, 2'b11);
        btn_mode = 0; cyc(); btn_mode = 1; cyc();
        chk("m_rise_3", mode, 2'b00);
        btn_mode = 0; cyc();

        // Clock edit: S, up x3, S, up x2, S.
        inc_seen = 0;
        press_s();
        repeat (3) press_u();
        press_s();
        repeat (2) press_u();
        press_s();
        chk("inc_count", inc_seen[1:0] == 2'd1 && inc_seen == 5 ? 2'b01 : 2'b00, 2'b01);
        chk("edit_clk_exit", {1'b0, edit_clk}, 2'b00);

        // Inactivity timeout from ALARM.
        press_m();
        repeat (9) tick();
        chk("alarm_tick9", mode, 2'b10);
        tick();
        chk("alarm_tick10", mode, 2'b00);
        press_m();
        repeat (8) tick();
        btn_up = 1; tick();
        repeat (9) tick();
        chk("restart_tick9", mode, 2'b10);
        tick();
        chk("restart_tick10", mode, 2'b00);
        btn_up = 0; cyc();

        // Simultaneous mode/set/up edges in ALM_EDIT_M.
        press_m(); press_s(); press_s();
        chk("in_alm_edit_m", {edit_alm, edit_sel}, 2'b10);
        btn_mode = 1; btn_set = 1; btn_up = 1; cyc();
        chk("simul_mode", mode, 2'b10);
        chk("simul_edit", {edit_alm, inc_pulse}, 2'b00);
        btn_mode = 0; btn_set = 0; btn_up = 0; cyc();
        press_m(); press_m();

        // Blink phase in CLK_EDIT_H, with an up edge mid-phase.
        press_s();
        repeat (4) tick();
        tick_1hz = 1; cyc(); tick_1hz = 0;
        press_u();
        repeat (2) tick();
        press_m();

        // Randomized traffic; quiet blocks let the timeout expire.
        for (int blk = 0; blk < 20; blk++) begin
            int flip_rate;
            flip_rate = ($urandom_range(0, 1) == 0) ? 6 : 60;
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, flip_rate - 1) == 0) btn_mode = ~btn_mode;
                if ($urandom_range(0, flip_rate - 1) == 0) btn_set = ~btn_set;
                if ($urandom_range(0, flip_rate - 1) == 0) btn_up = ~btn_up;
                tick_1hz = ($urandom_range(0, 3) == 0);
                rst = ($urandom_range(0, 499) == 0);
                cyc();
            end
        end
        rst = 0; tick_1hz = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
